out_channel_checker: RTL and testbench

- Downstream consumer of the program engine's out channel: accepts each word the engine writes to its output area, buffers it, and compares it in order against an expected-value table loaded before the run.
- Replaces the hard-coded end-of-program check (success = outMem[k] == const) with a reusable block.
- Drives finished/success plus diagnostics once the engine has halted and all buffered words have been checked.

---
 rtl/out_check_pkg.sv | 16 +
 rtl/out_fifo.sv | 58 +++++
 rtl/out_channel_checker.sv | 148 ++++++++++++++
 tb/tb_out_channel_checker.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_check_pkg.sv
// Shared state encoding and constants for the out-channel checker and its FIFO.
package out_check_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int MEMORY_ELEMENT_WIDTH = 12;

   // Wide enough for any counter width; users take the low CountWidth bits.
   localparam int                         SENTINEL_WIDTH = 64;
   localparam logic [SENTINEL_WIDTH-1:0]  FIRST_BAD_NONE = '1;

endpackage

// File: rtl/out_fifo.sv
// Synchronous FIFO with a combinational head word; pointers wrap naturally.
module out_fifo
   import out_check_pkg::*;
#(
   parameter int Width = MEMORY_ELEMENT_WIDTH,
   parameter int Depth = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   i_push,
   input  logic [Width-1:0]       i_push_data,
   input  logic                   i_pop,
   output logic [Width-1:0]       o_head_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(Depth):0] o_occupancy
);

   localparam int                PtrWidth  = $clog2(Depth);
   localparam logic [PtrWidth:0] DepthFull = (PtrWidth + 1)'(Depth);

   logic [Width-1:0]    r_mem [Depth];
   logic [PtrWidth-1:0] r_wr_ptr;
   logic [PtrWidth-1:0] r_rd_ptr;
   logic [PtrWidth:0]   r_count;
   logic                w_do_push;
   logic                w_do_pop;

   assign o_full      = (r_count == DepthFull);
   assign o_empty     = (r_count == '0);
   assign o_occupancy = r_count;
   assign o_head_data = r_mem[r_rd_ptr];
   assign w_do_push   = i_push && !o_full;
   assign w_do_pop    = i_pop && !o_empty;

   // NOTE: storage arrays carry no reset; the pointers alone decide what is valid.
   always_ff @(posedge clock) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/out_channel_checker.sv
// Buffers out-channel words and compares them in order against a preloaded
// expected-value table; reports finished/success once the engine has halted.
module out_channel_checker
   import out_check_pkg::*;
#(
   parameter int MemoryElementWidth = MEMORY_ELEMENT_WIDTH,
   parameter int NOut               = 2000,
   parameter int FifoDepth          = 8,
   parameter int CountWidth         = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          expWrite,
   input  logic [MemoryElementWidth-1:0] expData,
   input  logic                          start,
   input  logic                          outValid,
   input  logic [MemoryElementWidth-1:0] outData,
   output logic                          outReady,
   input  logic                          halted,
   output logic                          finished,
   output logic                          success,
   output logic [CountWidth-1:0]         rxCount,
   output logic [CountWidth-1:0]         mismatches,
   output logic [CountWidth-1:0]         firstBad
);

   localparam int                    AddrWidth   = $clog2(NOut);
   localparam int                    OccWidth    = $clog2(FifoDepth) + 1;
   localparam logic [CountWidth-1:0] CountMax    = '1;
   localparam logic [CountWidth-1:0] TableSize   = CountWidth'(NOut);
   localparam logic [CountWidth-1:0] NoneFlagged = FIRST_BAD_NONE[CountWidth-1:0];

   state_t                        r_state;
   logic [MemoryElementWidth-1:0] r_table [NOut];
   logic [CountWidth-1:0]         r_exp_count;
   logic [CountWidth-1:0]         r_rd_idx;
   logic [CountWidth-1:0]         r_rx_count;
   logic [CountWidth-1:0]         r_mismatches;
   logic [CountWidth-1:0]         r_first_bad;
   logic                          r_stage_valid;
   logic [MemoryElementWidth-1:0] r_stage_data;
   logic [MemoryElementWidth-1:0] r_exp_q;
   logic                          r_finished;
   logic                          r_success;

   logic                          w_push;
   logic                          w_pop;
   logic                          w_full;
   logic                          w_empty;
   logic [OccWidth-1:0]           w_occ;
   logic [MemoryElementWidth-1:0] w_head;
   logic                          w_table_wr;
   logic                          w_rd_in_range;
   logic                          w_mismatch;
   logic                          w_halt_done;

   out_fifo #(
      .Width (MemoryElementWidth),
      .Depth (FifoDepth)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data (outData),
      .i_pop       (w_pop),
      .o_head_data (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_occupancy (w_occ)
   );

   assign outReady      = (r_state == RUN) && !w_full;
   assign w_push        = outValid && outReady;
   assign w_pop         = (r_state == RUN) && !w_empty;
   assign w_table_wr    = (r_state == LOAD) && expWrite && (r_exp_count < TableSize);
   assign w_rd_in_range = (r_rd_idx < TableSize);

   // Index past expCount is an unexpected extra word, whatever the stale table holds.
   assign w_mismatch    = (r_stage_data != r_exp_q) || (r_rx_count >= r_exp_count);

   // A word accepted on this very edge still has to be checked before DONE.
   assign w_halt_done   = halted && (w_occ == '0) && !r_stage_valid && !w_push;

   assign finished      = r_finished;
   assign success       = r_success;
   assign rxCount       = r_rx_count;
   assign mismatches    = r_mismatches;
   assign firstBad      = r_first_bad;

   // Expected table: one write port in LOAD, registered read feeding the compare stage.
   always_ff @(posedge clock) begin
      if (w_table_wr)             r_table[r_exp_count[AddrWidth-1:0]] <= expData;
      if (w_pop && w_rd_in_range) r_exp_q <= r_table[r_rd_idx[AddrWidth-1:0]];
   end

   always_ff @(posedge clock) begin
      if (w_pop) r_stage_data <= w_head;
   end

   // NOTE: reset is asynchronous, so every register in this block clears without a clock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= LOAD;
         r_exp_count <= '0;
         r_finished  <= 1'b0;
         r_success   <= 1'b0;
      end else begin
         case (r_state)
            LOAD: begin
               if (w_table_wr) r_exp_count <= r_exp_count + 1'b1;
               if (start)      r_state     <= RUN;
            end
            RUN: begin
               if (w_halt_done) begin
                  r_state    <= DONE;
                  r_finished <= 1'b1;
                  r_success  <= (r_mismatches == '0) && (r_rx_count == r_exp_count);
               end
            end
            DONE:    r_state <= DONE;
            default: r_state <= LOAD;
         endcase
      end
   end

   // Pop stage reads the table one cycle ahead; compare stage updates the counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rd_idx      <= '0;
         r_stage_valid <= 1'b0;
         r_rx_count    <= '0;
         r_mismatches  <= '0;
         r_first_bad   <= NoneFlagged;
      end else begin
         r_stage_valid <= w_pop;
         if (w_pop && (r_rd_idx != CountMax)) r_rd_idx <= r_rd_idx + 1'b1;

         if (r_stage_valid) begin
            if (r_rx_count != CountMax) r_rx_count <= r_rx_count + 1'b1;
            if (w_mismatch) begin
               if (r_mismatches != CountMax)  r_mismatches <= r_mismatches + 1'b1;
               if (r_first_bad == NoneFlagged) r_first_bad <= r_rx_count;
            end
         end
      end
   end

endmodule

// File: tb/tb_out_channel_checker.sv
// Directed bench for out_channel_checker with hand-computed expectations.
module tb_out_channel_checker;
   import out_check_pkg::*;

   localparam int               W     = 12;
   localparam int               CW    = 16;
   localparam int               DEPTH = 4;
   localparam logic [CW-1:0]    NONE  = 16'hFFFF;

   logic          clock = 1'b0;
   logic          reset;
   logic          expWrite;
   logic [W-1:0]  expData;
   logic          start;
   logic          outValid;
   logic [W-1:0]  outData;
   logic          outReady;
   logic          halted;
   logic          finished;
   logic          success;
   logic [CW-1:0] rxCount;
   logic [CW-1:0] mismatches;
   logic [CW-1:0] firstBad;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   out_channel_checker #(
      .MemoryElementWidth (W),
      .NOut               (2000),
      .FifoDepth          (DEPTH),
      .CountWidth         (CW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .expWrite   (expWrite),
      .expData    (expData),
      .start      (start),
      .outValid   (outValid),
      .outData    (outData),
      .outReady   (outReady),
      .halted     (halted),
      .finished   (finished),
      .success    (success),
      .rxCount    (rxCount),
      .mismatches (mismatches),
      .firstBad   (firstBad)
   );

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      expWrite = 1'b0;
      expData  = '0;
      start    = 1'b0;
      outValid = 1'b0;
      outData  = '0;
      halted   = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic load_word(input logic [W-1:0] v);
      expWrite = 1'b1;
      expData  = v;
      tick();
      expWrite = 1'b0;
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_word(input string tag, input logic [W-1:0] v);
      logic taken;
      taken    = 1'b0;
      outValid = 1'b1;
      outData  = v;
      for (int i = 0; i < 20 && !taken; i++) begin
         taken = outReady;
         tick();
      end
      outValid = 1'b0;
      check({tag, "_accepted"}, taken, 1);
   endtask

   task automatic finish_run(input string tag, input int budget);
      halted = 1'b1;
      for (int i = 0; i < budget && !finished; i++) tick();
      check({tag, "_finished"}, finished, 1);
   endtask

   task automatic check_result(input string tag, input logic exp_success, input logic [CW-1:0] exp_rx,
                               input logic [CW-1:0] exp_mism, input logic [CW-1:0] exp_fb);
      check({tag, "_success"},    success,    exp_success);
      check({tag, "_rxCount"},    rxCount,    exp_rx);
      check({tag, "_mismatches"}, mismatches, exp_mism);
      check({tag, "_firstBad"},   firstBad,   exp_fb);
   endtask

   initial begin
      logic [W-1:0] vals [20];
      int           occ;
      int           sent;
      logic         exp_ready;
      logic         push;

      idle_inputs();
      reset = 1'b1;
      apply_reset();

      // Reset state
      check("rst_finished",   finished,   0);
      check("rst_success",    success,    0);
      check("rst_outReady",   outReady,   0);
      check("rst_rxCount",    rxCount,    0);
      check("rst_mismatches", mismatches, 0);
      check("rst_firstBad",   firstBad,   NONE);

      // Single word, matches
      load_word(12'd0);
      start_run();
      check("t1_ready_in_run", outReady, 1);
      send_word("t1_w0", 12'd0);
      finish_run("t1", 50);
      check_result("t1", 1'b1, 16'd1, 16'd0, NONE);

      // Asynchronous reset from DONE clears registered outputs without a clock edge
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("t1_async_finished", finished, 0);
      check("t1_async_success",  success,  0);
      check("t1_async_rxCount",  rxCount,  0);
      reset = 1'b0;
      idle_inputs();
      tick();

      // One mid-stream mismatch
      apply_reset();
      load_word(12'd3);
      load_word(12'd0);
      load_word(12'd7);
      start_run();
      send_word("t2_w0", 12'd3);
      send_word("t2_w1", 12'd5);
      send_word("t2_w2", 12'd7);
      finish_run("t2", 50);
      check_result("t2", 1'b0, 16'd3, 16'd1, 16'd1);

      // Extra unexpected word
      apply_reset();
      load_word(12'd1);
      load_word(12'd2);
      start_run();
      send_word("t3a_w0", 12'd1);
      send_word("t3a_w1", 12'd2);
      send_word("t3a_w2", 12'd9);
      finish_run("t3a", 50);
      check_result("t3a", 1'b0, 16'd3, 16'd1, 16'd2);

      // Too few words
      apply_reset();
      load_word(12'd1);
      load_word(12'd2);
      start_run();
      send_word("t3b_w0", 12'd1);
      finish_run("t3b", 50);
      check_result("t3b", 1'b0, 16'd1, 16'd0, NONE);

      // Empty table, no words
      apply_reset();
      start_run();
      finish_run("t_empty", 50);
      check_result("t_empty", 1'b1, 16'd0, 16'd0, NONE);

      // Streaming 20 words with halted high from the start
      apply_reset();
      for (int i = 0; i < 20; i++) vals[i] = W'((i * 37 + 5) % 4096);
      halted = 1'b1;
      for (int i = 0; i < 20; i++) load_word(vals[i]);
      tick();
      check("t4_load_halt_finished", finished, 0);
      check("t4_load_halt_ready",    outReady, 0);
      start_run();
      occ  = 0;
      sent = 0;
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
         outValid  = (sent < 20);
         outData   = vals[(sent < 20) ? sent : 19];
         exp_ready = (occ < DEPTH);
         check("t4_outReady", outReady, exp_ready);
         push = outValid && exp_ready;
         occ  = occ + (push ? 1 : 0) - ((occ > 0) ? 1 : 0);
         sent = sent + (push ? 1 : 0);
         tick();
      end
      outValid = 1'b0;
      check("t4_sent", sent, 20);
      check("t4_finished", finished, 1);
      check_result("t4", 1'b1, 16'd20, 16'd0, NONE);

      // Asynchronous reset mid-RUN
      apply_reset();
      load_word(12'd10);
      load_word(12'd11);
      load_word(12'd12);
      load_word(12'd13);
      start_run();
      outValid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         outData = W'(10 + k);
         tick();
      end
      check("t5_pre_reset_rx", rxCount, 1);
      #2;
      reset = 1'b1;
      #1;
      check("t5_async_outReady",   outReady,   0);
      check("t5_async_rxCount",    rxCount,    0);
      check("t5_async_mismatches", mismatches, 0);
      check("t5_async_firstBad",   firstBad,   NONE);
      check("t5_async_finished",   finished,   0);
      idle_inputs();
      tick();
      reset = 1'b0;
      tick();
      load_word(12'd5);
      start_run();
      send_word("t5_w0", 12'd5);
      finish_run("t5", 50);
      check_result("t5", 1'b1, 16'd1, 16'd0, NONE);

      // expWrite ignored in RUN and DONE; outValid ignored in DONE
      apply_reset();
      load_word(12'd4);
      start_run();
      expWrite = 1'b1;
      expData  = 12'd9;
      tick();
      expWrite = 1'b0;
      send_word("t6_w0", 12'd4);
      finish_run("t6", 50);
      check_result("t6", 1'b1, 16'd1, 16'd0, NONE);
      expWrite = 1'b1;
      outValid = 1'b1;
      outData  = 12'd4;
      for (int k = 0; k < 3; k++) begin
         check("t6_done_ready", outReady, 0);
         tick();
      end
      idle_inputs();
      tick();
      tick();
      check("t6_done_rxCount",  rxCount,  1);
      check("t6_done_finished", finished, 1);
      check("t6_done_success",  success,  1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
